dig_scroll: RTL and testbench

- Upstream feeder for the six-digit seven-segment scan driver.
- Stores a message of 6-bit character codes in a small register file and presents a sliding 6-character window on six registered code outputs.
- The window advances one character per scroll period, wrapping around the message.
- The scan driver's six digit-code inputs connect directly to `dig_out1`..`dig_out6`; `dig_out1` is the leftmost character.

---
 rtl/dig_scroll.sv | 187 ++++++++++++++++++
 tb/tb_dig_scroll.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dig_scroll.sv
// dig_scroll: message store plus sliding six-character window feeding the
// six-digit seven-segment scan driver. A message of 6-bit character codes is
// written into a small register array; after start the window is filled with
// six LOAD shifts and then advances one character every DIV clocks, wrapping
// around the message.
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   asynchronous, active-high reset
//   wr_en/wr_addr/wr_data message storage write port (accepted in any state)
//   msg_len               message length, sampled on start (clamped to MSG_DEPTH)
//   start                 pulse: (re)load window and begin scrolling
//   stop                  pulse: return to IDLE and blank the window
//   pause                 level: freezes the scroll prescaler in RUN
//   busy                  high in LOAD or RUN
//   wrap                  one-cycle pulse after a shift that wrapped the fetch index
//   dig_out1..dig_out6    registered window codes, dig_out1 is leftmost
//
// Build option:
//   DIG_SCROLL_GAP_EN     when defined, six BLANK_CODE positions follow the
//                         message before it repeats (period L+6); otherwise the
//                         message wraps seamlessly (period L).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | window blank, waiting for start
// LOAD    | one shift per cycle until six characters are in the window
// RUN     | one shift per DIV un-paused prescaler cycles

module dig_scroll #(
   parameter int              MSG_DEPTH  = 32,
   parameter int              AW         = 5,
   parameter int              DIV        = 20000000,
   parameter logic [5:0]      BLANK_CODE = 6'd0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [5:0]    wr_data,
   input  logic [AW:0]   msg_len,
   input  logic          start,
   input  logic          stop,
   input  logic          pause,
   output logic          busy,
   output logic          wrap,
   output logic [5:0]    dig_out1,
   output logic [5:0]    dig_out2,
   output logic [5:0]    dig_out3,
   output logic [5:0]    dig_out4,
   output logic [5:0]    dig_out5,
   output logic [5:0]    dig_out6
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   // Fetch index must reach MSG_DEPTH+5 when the gap is enabled.
   localparam int IW = AW + 2;

`ifdef DIG_SCROLL_GAP_EN
   localparam logic [IW-1:0] GAP_LEN = IW'(6);
`else
   localparam logic [IW-1:0] GAP_LEN = IW'(0);
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN
   } state_t;

   state_t        state_q, state_d;
   logic [5:0]    mem [0:MSG_DEPTH-1];
   logic [5:0]    win_q [0:5];
   logic [AW:0]   len_q;
   logic [IW-1:0] rd_idx_q;
   logic [2:0]    load_cnt_q;
   logic [PW-1:0] presc_q;
   logic          wrap_q;

   logic          start_ok;
   logic [AW:0]   len_clamp;
   logic [IW-1:0] period;
   logic          idx_last;
   logic [5:0]    fetch_char;
   logic          presc_tc;
   logic          do_shift;
   logic          do_restart;
   logic          do_clear;

   // A start with zero length is ignored entirely.
   assign start_ok   = start && (msg_len != '0);
   assign len_clamp  = (msg_len > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : msg_len;
   assign period     = IW'(len_q) + GAP_LEN;
   assign idx_last   = (rd_idx_q == period - IW'(1));
   assign fetch_char = (rd_idx_q < IW'(len_q)) ? mem[rd_idx_q[AW-1:0]] : BLANK_CODE;
   assign presc_tc   = (presc_q == PW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // stop beats start; start (valid length) restarts from any state.
   always_comb begin
      state_d    = state_q;
      do_shift   = 1'b0;
      do_restart = 1'b0;
      do_clear   = 1'b0;
      if (stop) begin
         state_d  = ST_IDLE;
         do_clear = 1'b1;
      end else if (start_ok) begin
         state_d    = ST_LOAD;
         do_restart = 1'b1;
      end else begin
         case (state_q)
            ST_LOAD: begin
               do_shift = 1'b1;
               if (load_cnt_q == 3'd5)
                  state_d = ST_RUN;
            end
            ST_RUN: begin
               if (!pause && presc_tc)
                  do_shift = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 6; k++)
            win_q[k] <= BLANK_CODE;
         len_q      <= '0;
         rd_idx_q   <= '0;
         load_cnt_q <= '0;
         presc_q    <= '0;
         wrap_q     <= 1'b0;
      end else begin
         wrap_q <= do_shift && idx_last;
         if (do_clear) begin
            for (int k = 0; k < 6; k++)
               win_q[k] <= BLANK_CODE;
            rd_idx_q   <= '0;
            load_cnt_q <= '0;
            presc_q    <= '0;
         end else if (do_restart) begin
            // Window is intentionally not cleared; LOAD overwrites it.
            len_q      <= len_clamp;
            rd_idx_q   <= '0;
            load_cnt_q <= '0;
            presc_q    <= '0;
         end else begin
            if (do_shift) begin
               for (int k = 0; k < 5; k++)
                  win_q[k] <= win_q[k+1];
               win_q[5] <= fetch_char;
               rd_idx_q <= idx_last ? '0 : rd_idx_q + IW'(1);
            end
            if (state_q == ST_LOAD) begin
               load_cnt_q <= load_cnt_q + 3'd1;
               presc_q    <= '0;
            end
            if (state_q == ST_RUN && !pause)
               presc_q <= presc_tc ? '0 : presc_q + PW'(1);
         end
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign wrap     = wrap_q;
   assign dig_out1 = win_q[0];
   assign dig_out2 = win_q[1];
   assign dig_out3 = win_q[2];
   assign dig_out4 = win_q[3];
   assign dig_out5 = win_q[4];
   assign dig_out6 = win_q[5];

endmodule

// File: tb/tb_dig_scroll.sv
// Self-checking bench for dig_scroll (DIV=4, MSG_DEPTH=32). Expected windows
// are produced by a character-level model of the scrolling message and queued
// as stimulus is driven; they are popped and compared when the DUT shifts.
module tb_dig_scroll;

   localparam int         DIV       = 4;
   localparam int         MSG_DEPTH = 32;
   localparam int         AW        = 5;
   localparam logic [5:0] BLANK     = 6'd0;
`ifdef DIG_SCROLL_GAP_EN
   localparam int GAP = 6;
`else
   localparam int GAP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [5:0]    wr_data = '0;
   logic [AW:0]   msg_len = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          pause = 1'b0;
   logic          busy, wrap;
   logic [5:0]    dig_out1, dig_out2, dig_out3, dig_out4, dig_out5, dig_out6;

   int checks = 0;
   int errors = 0;

   logic [5:0]  mem_m [0:MSG_DEPTH-1];
   logic [35:0] m_win;
   int          m_fetch;
   logic [36:0] exp_q [$];

   dig_scroll #(
      .MSG_DEPTH(MSG_DEPTH), .AW(AW), .DIV(DIV), .BLANK_CODE(BLANK)
   ) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .msg_len(msg_len), .start(start), .stop(stop), .pause(pause),
      .busy(busy), .wrap(wrap),
      .dig_out1(dig_out1), .dig_out2(dig_out2), .dig_out3(dig_out3),
      .dig_out4(dig_out4), .dig_out5(dig_out5), .dig_out6(dig_out6)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [35:0] win_now();
      return {dig_out1, dig_out2, dig_out3, dig_out4, dig_out5, dig_out6};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mem(int a, logic [5:0] d);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      tick();
      wr_en = 1'b0;
      mem_m[a] = d;
   endtask

   task automatic pulse_start(int len);
      msg_len = (AW+1)'(len); start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Model: next fetched character enters on the right; wrap expected when
   // the fetched index is the last of the period.
   task automatic expect_shift(int L);
      int p, idx;
      logic [5:0] c;
      p   = L + GAP;
      idx = m_fetch % p;
      c   = (idx < L) ? mem_m[idx] : BLANK;
      m_win = {m_win[29:0], c};
      exp_q.push_back({m_win, (idx == p - 1)});
      m_fetch++;
   endtask

   task automatic load_phase(string tag, int L);
      logic [36:0] e;
      for (int j = 1; j <= 6; j++) begin
         expect_shift(L);
         tick();
         e = exp_q.pop_front();
         checks++;
         if ({win_now(), wrap} !== e) begin
            errors++;
            $display("FAIL %s load shift %0d: got win=%h wrap=%b, want win=%h wrap=%b",
                     tag, j, win_now(), wrap, e[36:1], e[0]);
         end
      end
   endtask

   task automatic run_step(string tag, int L, bit do_wr, int wa, logic [5:0] wd);
      logic [35:0] hold;
      logic [36:0] e;
      hold = win_now();
      if (do_wr) begin
         wr_en = 1'b1; wr_addr = AW'(wa); wr_data = wd;
         mem_m[wa] = wd;
      end
      expect_shift(L);
      for (int k = 1; k < DIV; k++) begin
         tick();
         wr_en = 1'b0;
         checks++;
         if ({win_now(), wrap} !== {hold, 1'b0}) begin
            errors++;
            $display("FAIL %s hold cycle %0d: got win=%h wrap=%b, want win=%h wrap=0",
                     tag, k, win_now(), wrap, hold);
         end
      end
      tick();
      wr_en = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if ({win_now(), wrap} !== e) begin
         errors++;
         $display("FAIL %s step: got win=%h wrap=%b, want win=%h wrap=%b",
                  tag, win_now(), wrap, e[36:1], e[0]);
      end
   endtask

   task automatic check_idle(string tag);
      checks++;
      if ({busy, wrap, win_now()} !== {1'b0, 1'b0, 36'd0}) begin
         errors++;
         $display("FAIL %s: got busy=%b wrap=%b win=%h, want busy=0 wrap=0 win=0",
                  tag, busy, wrap, win_now());
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      rst = 1'b0;
      check_idle("reset_state");
      repeat (3) tick();
      check_idle("reset_quiet");
   endtask

   task automatic test_scroll();
      for (int a = 0; a < 8; a++) write_mem(a, 6'(a + 1));
      m_win = '0; m_fetch = 0; exp_q.delete();
      pulse_start(8);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL start_busy: got %b want 1", busy);
      end
      load_phase("scroll", 8);
      checks++;
      if (win_now() !== {6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6}) begin
         errors++;
         $display("FAIL scroll_window_full: got %h want 1..6", win_now());
      end
      for (int s = 0; s < 10; s++) run_step("scroll_run", 8, 1'b0, 0, 6'd0);
   endtask

   task automatic test_stop();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL stop_pre_busy: got %b want 1", busy);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_idle("stop_blank");
   endtask

   task automatic test_short_msg();
      write_mem(0, 6'd9); write_mem(1, 6'd10); write_mem(2, 6'd11);
      m_win = '0; m_fetch = 0; exp_q.delete();
      pulse_start(3);
      load_phase("short", 3);
      checks++;
`ifdef DIG_SCROLL_GAP_EN
      if (win_now() !== {6'd9, 6'd10, 6'd11, BLANK, BLANK, BLANK}) begin
`else
      if (win_now() !== {6'd9, 6'd10, 6'd11, 6'd9, 6'd10, 6'd11}) begin
`endif
         errors++;
         $display("FAIL short_window: got %h", win_now());
      end
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic test_pause();
      logic [35:0] hold;
      logic [36:0] e;
      write_mem(0, 6'd1); write_mem(1, 6'd2); write_mem(2, 6'd3);
      m_win = '0; m_fetch = 0; exp_q.delete();
      pulse_start(8);
      load_phase("pause", 8);
      hold = win_now();
      expect_shift(8);
      tick(); tick();
      pause = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if ({win_now(), wrap} !== {hold, 1'b0}) begin
            errors++;
            $display("FAIL pause_hold %0d: got win=%h want %h", k, win_now(), hold);
         end
      end
      pause = 1'b0;
      for (int k = 0; k < DIV - 3; k++) begin
         tick();
         checks++;
         if (win_now() !== hold) begin
            errors++;
            $display("FAIL pause_early_step: got win=%h want %h", win_now(), hold);
         end
      end
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({win_now(), wrap} !== e) begin
         errors++;
         $display("FAIL pause_step: got win=%h wrap=%b, want win=%h wrap=%b",
                  win_now(), wrap, e[36:1], e[0]);
      end
   endtask

   task automatic test_overwrite();
      run_step("overwrite", 8, 1'b1, 7, 6'd63);
      checks++;
      if (dig_out6 !== 6'd63) begin
         errors++;
         $display("FAIL overwrite_dig6: got %0d want 63", dig_out6);
      end
   endtask

   task automatic test_start_stop();
      msg_len = 7'd8; start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      check_idle("start_stop_same");
      pulse_start(0);
      check_idle("start_len0");
      repeat (3) tick();
      check_idle("start_len0_quiet");
   endtask

   task automatic test_len_clamp();
      for (int a = 0; a < MSG_DEPTH; a++) write_mem(a, 6'((a * 5 + 7) % 64));
      m_win = '0; m_fetch = 0; exp_q.delete();
      pulse_start(40);
      load_phase("clamp", 32);
      for (int s = 0; s < 34; s++) run_step("clamp_run", 32, 1'b0, 0, 6'd0);
   endtask

   task automatic test_async_reset();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre_busy: got %b want 1", busy);
      end
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check_idle("areset_immediate");
      #2 rst = 1'b0;
      repeat (5) tick();
      check_idle("areset_quiet");
   endtask

   initial begin
      test_reset();
      test_scroll();
      test_stop();
      test_short_msg();
      test_pause();
      test_overwrite();
      test_start_stop();
      test_len_clamp();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
